// File: rtl/ram_param_2r1w_valid_if.sv
// Bus bundle for ram_param_2r1w_valid: flush, one write port and two read ports.
interface ram_param_2r1w_valid_if #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic              flush;
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [WIDTH-1:0]  W0_data;
  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [WIDTH-1:0]  R0_data;
  logic              R0_valid;
  logic              R1_en;
  logic [ADDR_W-1:0] R1_addr;
  logic [WIDTH-1:0]  R1_data;
  logic              R1_valid;

  modport master (
    output flush, W0_en, W0_addr, W0_data,
    output R0_en, R0_addr, R1_en, R1_addr,
    input  R0_data, R0_valid, R1_data, R1_valid
  );

  modport slave (
    input  flush, W0_en, W0_addr, W0_data,
    input  R0_en, R0_addr, R1_en, R1_addr,
    output R0_data, R0_valid, R1_data, R1_valid
  );
endinterface

// File: rtl/ram_param_2r1w_valid.sv
// 2-read/1-write register-file RAM with per-entry valid bits, bulk flush,
// selectable read latency and write-to-read bypass; gated reads never return X.
module ram_param_2r1w_valid #(
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned BYPASS       = 1
) (
  input logic                    clock,
  input logic                    reset_n,
  ram_param_2r1w_valid_if.slave  bus
);
  localparam int unsigned ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic              wr_ok;

  logic              rd_en      [2];
  logic [ADDR_W-1:0] rd_addr    [2];
  logic [WIDTH-1:0]  rd_data_d  [2];
  logic              rd_valid_d [2];

  assign wr_ok = bus.W0_en && ({1'b0, bus.W0_addr} < DEPTH_C);

  // Flush clears first, then the write re-validates its own entry.
  always_comb begin
    valid_d = valid_q;
    if (bus.flush) valid_d = '0;
    if (wr_ok)     valid_d[bus.W0_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // Data array has no reset; a write landing during reset stays hidden
  // because its valid bit is held clear.
  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[bus.W0_addr] <= bus.W0_data;
  end

  assign rd_en[0]   = bus.R0_en;
  assign rd_en[1]   = bus.R1_en;
  assign rd_addr[0] = bus.R0_addr;
  assign rd_addr[1] = bus.R1_addr;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data_d[p]  = '0;
      rd_valid_d[p] = 1'b0;
      if (rd_en[p] && ({1'b0, rd_addr[p]} < DEPTH_C)) begin
        if ((BYPASS != 0) && wr_ok && (bus.W0_addr == rd_addr[p])) begin
          rd_data_d[p]  = bus.W0_data;
          rd_valid_d[p] = 1'b1;
        end else if (valid_q[rd_addr[p]]) begin
          rd_data_d[p]  = mem_q[rd_addr[p]];
          rd_valid_d[p] = 1'b1;
        end
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb
    assign bus.R0_data  = rd_data_d[0];
    assign bus.R0_valid = rd_valid_d[0];
    assign bus.R1_data  = rd_data_d[1];
    assign bus.R1_valid = rd_valid_d[1];
  end else if (READ_LATENCY == 1) begin : g_reg
    logic [WIDTH-1:0] rd_data_q  [2];
    logic             rd_valid_q [2];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned p = 0; p < 2; p++) begin
          rd_data_q[p]  <= '0;
          rd_valid_q[p] <= 1'b0;
        end
      end else begin
        for (int unsigned p = 0; p < 2; p++) begin
          rd_data_q[p]  <= rd_data_d[p];
          rd_valid_q[p] <= rd_valid_d[p];
        end
      end
    end

    assign bus.R0_data  = rd_data_q[0];
    assign bus.R0_valid = rd_valid_q[0];
    assign bus.R1_data  = rd_data_q[1];
    assign bus.R1_valid = rd_valid_q[1];
  end else begin : g_bad_latency
    $error("ram_param_2r1w_valid: READ_LATENCY must be 0 or 1");
  end

endmodule

// File: tb/tb_ram_param_2r1w_valid.sv
// Scoreboard bench: drives one stimulus stream into all four latency/bypass
// variants and compares each against a reference model of the RAM.
module tb_ram_param_2r1w_valid;
  localparam int unsigned W = 7;
  localparam int unsigned D = 3;

  typedef struct {
    logic [W-1:0] data;
    logic         valid;
    int           port;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         w_en;
  logic [1:0]   w_addr;
  logic [W-1:0] w_data;
  logic         r_en   [2];
  logic [1:0]   r_addr [2];

  logic [W-1:0] o_data  [4][2];
  logic         o_valid [4][2];

  logic [W-1:0] m_mem [D];
  logic         m_val [D];

  exp_t sb [4][$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  // Config g: READ_LATENCY = g/2, BYPASS = g%2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    ram_param_2r1w_valid_if #(.WIDTH(W), .DEPTH(D)) bus ();

    assign bus.flush   = flush;
    assign bus.W0_en   = w_en;
    assign bus.W0_addr = w_addr;
    assign bus.W0_data = w_data;
    assign bus.R0_en   = r_en[0];
    assign bus.R0_addr = r_addr[0];
    assign bus.R1_en   = r_en[1];
    assign bus.R1_addr = r_addr[1];

    assign o_data[g][0]  = bus.R0_data;
    assign o_valid[g][0] = bus.R0_valid;
    assign o_data[g][1]  = bus.R1_data;
    assign o_valid[g][1] = bus.R1_valid;

    ram_param_2r1w_valid #(
      .WIDTH(W), .DEPTH(D), .READ_LATENCY(g / 2), .BYPASS(g % 2)
    ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_read(input bit byp, input logic en, input logic [1:0] addr,
                                     output logic [W-1:0] d, output logic v);
    d = '0;
    v = 1'b0;
    if (en && addr < 2'd3) begin
      if (byp && w_en && w_addr < 2'd3 && w_addr == addr) begin
        d = w_data;
        v = 1'b1;
      end else if (m_val[addr]) begin
        d = m_mem[addr];
        v = 1'b1;
      end
    end
  endfunction

  task automatic check_sb(input int c);
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      e = sb[c].pop_front();
      check_eq($sformatf("c%0d_r%0d_data", c, e.port), 32'(o_data[c][e.port]), 32'(e.data));
      check_eq($sformatf("c%0d_r%0d_valid", c, e.port), 32'(o_valid[c][e.port]), 32'(e.valid));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 2; p++) begin
        check_eq($sformatf("%s_c%0d_r%0d_data", tag, c, p), 32'(o_data[c][p]), 32'd0);
        check_eq($sformatf("%s_c%0d_r%0d_valid", tag, c, p), 32'(o_valid[c][p]), 32'd0);
      end
    end
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input logic fl, input logic we, input logic [1:0] wa, input logic [W-1:0] wd,
                     input logic re0, input logic [1:0] ra0, input logic re1, input logic [1:0] ra1);
    exp_t e;
    flush = fl; w_en = we; w_addr = wa; w_data = wd;
    r_en[0] = re0; r_addr[0] = ra0; r_en[1] = re1; r_addr[1] = ra1;
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 2; p++) begin
        model_read((c % 2) == 1, r_en[p], r_addr[p], e.data, e.valid);
        e.port = p;
        sb[c].push_back(e);
      end
    end
    #3;
    check_sb(0);
    check_sb(1);
    @(posedge clock);
    if (flush) for (int i = 0; i < int'(D); i++) m_val[i] = 1'b0;
    if (w_en && w_addr < 2'd3) begin
      m_mem[w_addr] = w_data;
      m_val[w_addr] = 1'b1;
    end
    #1;
    check_sb(2);
    check_sb(3);
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0;
    r_en[0] = 1'b1; r_addr[0] = 2'd0; r_en[1] = 1'b1; r_addr[1] = 2'd1;
    for (int i = 0; i < int'(D); i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end

    repeat (2) @(posedge clock);
    #1;
    check_all_zero("rst");
    reset_n = 1'b1;

    // Empty RAM reads back 0/invalid on every address.
    for (int a = 0; a < 3; a++)
      cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'(a), 1'b1, 2'((a + 1) % 3));

    // Write then read (bypass visible during the write cycle).
    cyc(1'b0, 1'b1, 2'd1, 7'h5A, 1'b1, 2'd1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd1, 1'b1, 2'd1);

    // Collision on addr2 holding 7'h11.
    cyc(1'b0, 1'b1, 2'd2, 7'h11, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd0, 7'h22, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd2, 7'h33, 1'b1, 2'd2, 1'b1, 2'd0);
    cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd2, 1'b1, 2'd2);

    // Flush together with a write to addr0.
    cyc(1'b1, 1'b1, 2'd0, 7'h7F, 1'b1, 2'd1, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd0, 1'b1, 2'd1);
    cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd2, 1'b1, 2'd0);

    // Out-of-range write and read.
    cyc(1'b0, 1'b1, 2'd3, 7'h01, 1'b1, 2'd3, 1'b1, 2'd0);
    cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd0, 1'b1, 2'd1);
    cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd2, 1'b1, 2'd3);

    // Flush alone, then flush colliding with a bypassed write.
    cyc(1'b1, 1'b0, 2'd0, 7'h00, 1'b1, 2'd0, 1'b1, 2'd0);
    cyc(1'b0, 1'b1, 2'd1, 7'h2C, 1'b1, 2'd0, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 2'd0, 7'h4D, 1'b1, 2'd0, 1'b1, 2'd1);
    cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd0, 1'b1, 2'd1);

    for (int n = 0; n < 60; n++)
      cyc($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          7'($urandom()), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    // Async reset mid-cycle while LAT=1 outputs hold 7'h5A.
    cyc(1'b0, 1'b1, 2'd1, 7'h5A, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd1, 1'b1, 2'd1);
    check_eq("hold_lat1_data", 32'(o_data[2][0]), 32'h5A);
    w_en = 1'b1; w_addr = 2'd0; w_data = 7'h44;
    #1 reset_n = 1'b0;
    #1 check_all_zero("arst");
    @(posedge clock);
    #1 check_all_zero("arst_hold");
    w_en = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < int'(D); i++) m_val[i] = 1'b0;
    @(posedge clock);
    #1;
    for (int a = 0; a < 3; a++)
      cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 2'(a), 1'b1, 2'((a + 2) % 3));

    for (int c = 0; c < 4; c++)
      check_eq($sformatf("sb_drain_c%0d", c), 32'(sb[c].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_param_2r1w_valid.md
Name: ram_param_2r1w_valid

Overview:
- Parametrised successor to the small 1R1W register-file RAMs used for ROB-indexed side-band fields such as fflags and rob_idx.
- Provides two read ports, one write port and a per-entry valid bit with bulk flush, so consumers no longer need a separate valid array.
- Read data is deterministic: zero when a read is disabled, invalid or out of range, never X.
- Read latency and write-to-read bypass are selectable, so one module replaces the family of fixed-size RAMs in the ROB and FP status paths.

Parameters:
- WIDTH, 7, data bits per entry (>=1).
- DEPTH, 3, number of entries (>=2; need not be a power of two).
- ADDR_W, max(1,$clog2(DEPTH)), address width (derived; not overridden).
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read; other values are an elaboration error.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded; 0 = read returns pre-write contents.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  clears all valid bits at the next edge.
- W0_en  in  1  write enable.
- W0_addr  in  ADDR_W  write address.
- W0_data  in  WIDTH  write data.
- R0_en  in  1  read port 0 enable.
- R0_addr  in  ADDR_W  read port 0 address.
- R0_data  out  WIDTH  read port 0 data.
- R0_valid  out  1  read port 0 entry-valid.
- R1_en, R1_addr, R1_data, R1_valid: identical to port 0, independent.

Behaviour:
- Reset (reset_n=0, asynchronous): all valid bits = 0; registered outputs (READ_LATENCY=1) R*_data = 0 and R*_valid = 0. Data array is not reset.
- Write: at the edge with W0_en=1 and W0_addr<DEPTH: Memory[W0_addr] <= W0_data and valid[W0_addr] <= 1. Writes with W0_addr>=DEPTH are dropped; no state changes.
- Flush: at the edge with flush=1, all valid bits go to 0. Data is untouched.
- Flush and write in the same cycle: the flush applies first, then the write. After the edge, only W0_addr is valid and it holds W0_data.
- Read gating: a read port outputs data = 0 and valid = 0 when en=0, addr>=DEPTH, or the entry is invalid. Otherwise it outputs data = Memory[addr] and valid = 1.
- READ_LATENCY=0: outputs are combinational from the current state. The effect of a flush is seen only after the edge.
- READ_LATENCY=1: the gated result is sampled at the edge and held in output registers until the next edge. When en=0 the registered output is 0/0, not a hold.
- Bypass (BYPASS=1, W0_en=1, W0_addr==R*_addr<DEPTH, R*_en=1):
  - READ_LATENCY=0: the port outputs W0_data, valid=1, in the same cycle, even if flush=1.
  - READ_LATENCY=1: the registered output captures W0_data, valid=1.
- With BYPASS=0 the same collision returns the pre-write entry and its pre-write valid. With READ_LATENCY=1 the registered output captures the pre-edge state.
- With BYPASS=0 and flush=1, a READ_LATENCY=1 read captures pre-flush valid and data.
- Both read ports may address the same entry, and each other's entries, with no interaction.
- If reset_n is asserted mid-operation, an in-flight write is lost and outputs go to 0 immediately. No X may propagate to any output after reset is released.

Test Plan:
- Reset then read: reset_n=0 for 2 cycles, release, R0_en=R1_en=1 on addrs 0..2 -> data 7'h00, valid 0 on both ports.
- Write/read: write addr1=7'h5A, then (LAT=0) read addr1 on both ports -> 7'h5A valid=1 next cycle. LAT=1 -> 7'h5A one cycle after the read is presented.
- Collision: W0 addr2=7'h33 while R0 reads addr2 (previously 7'h11, valid).
  - BYPASS=1, LAT=0 -> R0_data=7'h33 in the same cycle.
  - BYPASS=0, LAT=0 -> 7'h11 in the same cycle.
  - BYPASS=1, LAT=1 -> registered 7'h33.
  - BYPASS=0, LAT=1 -> registered 7'h11.
- Flush+write: entries 0..2 valid. Assert flush with a write of addr0=7'h7F -> next cycle addr0 valid and 7'h7F; addr1 and addr2 valid=0, data=0.
- Out of range: write addr3=7'h01 (DEPTH=3) -> no change to entries 0..2. Read addr3 -> data 0, valid 0.
- Async reset mid-stream: pulse reset_n low between edges while LAT=1 outputs hold 7'h5A -> outputs 0 immediately; all entries invalid after release.
